// File: rtl/tnet_tx_framer.sv
// tnet_tx_framer
//   Packs tProc network messages (header + three payload words) into two-beat
//   64-bit AXI-Stream frames for the Aurora TX user interface. Messages are
//   queued in a small FIFO. An 8-bit sequence number replaces header bits
//   [7:0]. Traffic is gated on channel_up. Sent and dropped frames are counted.
//
// Ports
//   user_clk_i          Aurora user clock (rising edge)
//   user_rst_i          asynchronous active-high reset
//   channel_up_i        Aurora channel up; low aborts, flushes and drops
//   msg_valid_i/ready_o message handshake; ready is forced high while down
//   msg_hdr_i           header, bits [7:0] replaced by the sequence number
//   msg_dt1_i..dt3_i    payload words
//   m_axi_tx_*          AXI-Stream master toward the Aurora TX core
//   fifo_cnt_o          FIFO occupancy
//   pkt_cnt_o           frames fully sent (wrapping)
//   drop_cnt_o          messages discarded (wrapping)
//   busy_o              FIFO non-empty or a frame in progress
module tnet_tx_framer #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          user_clk_i,
  input  logic          user_rst_i,
  input  logic          channel_up_i,
  input  logic          msg_valid_i,
  output logic          msg_ready_o,
  input  logic [31:0]   msg_hdr_i,
  input  logic [31:0]   msg_dt1_i,
  input  logic [31:0]   msg_dt2_i,
  input  logic [31:0]   msg_dt3_i,
  output logic [63:0]   m_axi_tx_tdata_o,
  output logic          m_axi_tx_tvalid_o,
  output logic          m_axi_tx_tlast_o,
  input  logic          m_axi_tx_tready_i,
  output logic [AW:0]   fifo_cnt_o,
  output logic [15:0]   pkt_cnt_o,
  output logic [15:0]   drop_cnt_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  localparam logic [AW:0]   DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Entry layout: {hdr[31:8], dt1, dt2, dt3}
  logic [119:0]  mem [FIFO_DEPTH];
  logic [119:0]  rd_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          push, pop, ld_beat0, ld_beat1, frame_done;
  logic [31:0]   hold_dt2_p0, hold_dt3_p0;
  logic [7:0]    seq_q, seq_beat0;
  logic [15:0]   pkt_q, drop_q, drop_inc;
  logic [63:0]   tdata_q;
  logic          tvalid_q, tlast_q;
  state_t        state_q, state_d;
  logic          unused_hdr_lsb;

  assign unused_hdr_lsb = ^msg_hdr_i[7:0];

  // While the channel is down every message is acknowledged and dropped.
  assign msg_ready_o = ~full_q | ~channel_up_i;
  assign push        = msg_valid_i & ~full_q & channel_up_i;
  assign rd_entry    = mem[rd_ptr];
  assign cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  // A back-to-back frame is loaded on the same edge that closes the previous
  // one, so it must carry the already-incremented sequence number.
  assign seq_beat0 = frame_done ? seq_q + 8'd1 : seq_q;

  // Abort accounting: in-flight frame + flushed entries + message offered now.
  assign drop_inc = 16'(msg_valid_i) + 16'(state_q != IDLE) + 16'(cnt_q);

  always_ff @(posedge user_clk_i) begin
    if (push) mem[wr_ptr] <= {msg_hdr_i[31:8], msg_dt1_i, msg_dt2_i, msg_dt3_i};
  end

  always_ff @(posedge user_clk_i) begin
    if (pop) {hold_dt2_p0, hold_dt3_p0} <= rd_entry[63:0];
  end

  // empty_q follows the previous occupancy: a fresh entry becomes visible one
  // cycle after its write. Pops are always at least two edges apart (a frame
  // is two beats), so the lag can never let a pop hit an empty FIFO.
  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (!channel_up_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_V);
      empty_q <= (cnt_q == '0);
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i)         drop_q <= '0;
    else if (!channel_up_i) drop_q <= drop_q + drop_inc;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    ld_beat0   = 1'b0;
    ld_beat1   = 1'b0;
    frame_done = 1'b0;
    if (!channel_up_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty_q) begin
            pop      = 1'b1;
            ld_beat0 = 1'b1;
            state_d  = BEAT0;
          end
        end
        BEAT0: begin
          if (m_axi_tx_tready_i) begin
            ld_beat1 = 1'b1;
            state_d  = BEAT1;
          end
        end
        BEAT1: begin
          if (m_axi_tx_tready_i) begin
            frame_done = 1'b1;
            if (!empty_q) begin
              pop      = 1'b1;
              ld_beat0 = 1'b1;
              state_d  = BEAT0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      seq_q    <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= (state_d != IDLE);
      tlast_q  <= (state_d == BEAT1);
      if (ld_beat0)      tdata_q <= {rd_entry[119:96], seq_beat0, rd_entry[95:64]};
      else if (ld_beat1) tdata_q <= {hold_dt2_p0, hold_dt3_p0};
      if (frame_done) begin
        seq_q <= seq_q + 8'd1;
        pkt_q <= pkt_q + 16'd1;
      end
    end
  end

  assign m_axi_tx_tdata_o  = tdata_q;
  assign m_axi_tx_tvalid_o = tvalid_q;
  assign m_axi_tx_tlast_o  = tlast_q;
  assign fifo_cnt_o        = cnt_q;
  assign pkt_cnt_o         = pkt_q;
  assign drop_cnt_o        = drop_q;
  assign busy_o            = (cnt_q != '0) | (state_q != IDLE);

endmodule
